// File: rtl/multdiv_ctrl_if.sv
// multdiv_ctrl_if: control bus between the mult/div sequencer and the
// iterative datapath/issuer side.
//   ctrl_mult, ctrl_div : start pulses (issuer -> sequencer)
//   divisor_zero        : datapath status, meaningful in the LOAD cycle
//   mult_ovf            : datapath status, meaningful in the DONE cycle
//   load, step, is_div  : datapath controls (sequencer -> datapath)
//   count, busy         : progress / occupancy
//   result_rdy          : one-cycle result strobe
//   exception           : qualifies result_rdy (div-by-zero or mult overflow)
// Modports: master = issuer/datapath side, slave = sequencer.
interface multdiv_ctrl_if #(
   parameter int CNT_W = 6
);
   logic             ctrl_mult;
   logic             ctrl_div;
   logic             divisor_zero;
   logic             mult_ovf;
   logic             load;
   logic             step;
   logic             is_div;
   logic [CNT_W-1:0] count;
   logic             busy;
   logic             result_rdy;
   logic             exception;

   modport master (
      output ctrl_mult, ctrl_div, divisor_zero, mult_ovf,
      input  load, step, is_div, count, busy, result_rdy, exception
   );

   modport slave (
      input  ctrl_mult, ctrl_div, divisor_zero, mult_ovf,
      output load, step, is_div, count, busy, result_rdy, exception
   );
endinterface

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencer for the iterative multiplier/divider datapath.
// A start pulse issues one LOAD cycle, then N step cycles (MULT_STEPS or
// DIV_STEPS), then a one-cycle result_rdy strobe. Divide-by-zero skips the
// step phase entirely. A new start in any state restarts the sequence.
// Ports:
//   clk : clock, rising edge
//   clr : synchronous active-high reset
//   bus : multdiv_ctrl_if.slave (start pulses, datapath status, controls)
module multdiv_ctrl #(
   parameter int MULT_STEPS = 16,
   parameter int DIV_STEPS  = 32,
   parameter int CNT_W      = 6
) (
   input logic           clk,
   input logic           clr,
   multdiv_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

   state_t           state, state_nxt;
   logic             is_div_q;
   logic [CNT_W-1:0] count_q;
   logic             dz;
   logic             start;
   logic [CNT_W-1:0] last;

   assign start = bus.ctrl_mult | bus.ctrl_div;
   assign last  = is_div_q ? DIV_LAST : MULT_LAST;

   // state register
   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic; a start pre-empts whatever is in flight
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = LOAD;
      end else begin
         case (state)
            IDLE: state_nxt = IDLE;
            LOAD: state_nxt = (is_div_q && bus.divisor_zero) ? DONE : RUN;
            RUN:  state_nxt = (count_q == last) ? DONE : RUN;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // op select, step counter and divide-by-zero flag
   always_ff @(posedge clk) begin
      if (clr) begin
         is_div_q <= 1'b0;
         count_q  <= '0;
         dz       <= 1'b0;
      end else if (start) begin
         // multiply wins when both starts arrive together
         is_div_q <= bus.ctrl_div & ~bus.ctrl_mult;
         count_q  <= '0;
      end else if (state == LOAD) begin
         dz <= is_div_q & bus.divisor_zero;
      end else if (state == RUN) begin
         // counts 0..N-1 across RUN, lands on N in DONE
         count_q <= count_q + 1'b1;
      end
   end

   // outputs: all Moore except exception, which folds in mult_ovf
   // because the datapath only knows about overflow in the DONE cycle
   always_comb begin
      bus.load       = (state == LOAD);
      bus.step       = (state == RUN);
      bus.busy       = (state == LOAD) || (state == RUN);
      bus.result_rdy = (state == DONE);
      bus.exception  = (state == DONE) && (dz || (!is_div_q && bus.mult_ovf));
      bus.is_div     = is_div_q;
      bus.count      = count_q;
   end

endmodule
